// File: rtl/audio_dac_serializer_if.sv
// Sample handshake between the audio datapath and the DAC serializer.
// The datapath acts as master; the serializer is the slave.
interface audio_dac_serializer_if #(
    parameter int SAMPLE_W = 16
);
    logic [SAMPLE_W-1:0] sample_left;
    logic [SAMPLE_W-1:0] sample_right;
    logic                sample_valid;
    logic                sample_ready;

    modport master (
        output sample_left,
        output sample_right,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_left,
        input  sample_right,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/audio_dac_serializer.sv
// Stereo MSB-first serializer onto AUD_DACDAT, framed by the codec's AUD_DACLRCK.
// One-entry pair buffer, left-justified or I2S alignment, zero/repeat underrun fill.
module audio_dac_serializer #(
    parameter int SAMPLE_W      = 16,
    parameter bit I2S_MODE      = 1'b1,
    parameter bit UNDERRUN_ZERO = 1'b0
) (
    input  logic                         AUD_BCLK,
    input  logic                         rst,
    input  logic                         AUD_DACLRCK,
    audio_dac_serializer_if.slave        smp,
    output logic                         AUD_DACDAT,
    output logic                         frame_done,
    output logic                         underrun,
    output logic [7:0]                   underrun_count
);
    typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} state_t;

    localparam logic [4:0] CNT_TOP = 5'(SAMPLE_W - 1);

    state_t              state, state_nxt;
    logic [4:0]          cnt, cnt_nxt;
    logic                chan_left, chan_nxt;
    logic                dac_nxt, done_nxt;

    logic                lrck_q;
    logic                edge_det, left_start;
    logic                full, accept, bypass, starve;
    logic [SAMPLE_W-1:0] buf_l, buf_r;
    logic [SAMPLE_W-1:0] shadow_l, shadow_r;
    logic [31:0]         cur_word;

    assign edge_det   = AUD_DACLRCK != lrck_q;
    assign left_start = edge_det && AUD_DACLRCK;

    assign smp.sample_ready = !full && !rst;
    assign accept = smp.sample_valid && smp.sample_ready;
    assign bypass = left_start && !full && smp.sample_valid;
    assign starve = left_start && !full && !smp.sample_valid;

    // Widened so the 5-bit counter indexes it exactly for any SAMPLE_W.
    assign cur_word = chan_left ? 32'(shadow_l) : 32'(shadow_r);

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        chan_nxt  = chan_left;
        dac_nxt   = 1'b0;
        done_nxt  = 1'b0;

        if (state == SHIFT) begin
            dac_nxt  = cur_word[cnt];
            done_nxt = (cnt == 5'd0) && !chan_left;
        end

        // IDLE only wakes on a left slot; elsewhere any edge restarts the slot.
        if (edge_det && (state != IDLE || AUD_DACLRCK)) begin
            state_nxt = I2S_MODE ? DELAY : SHIFT;
            cnt_nxt   = CNT_TOP;
            chan_nxt  = AUD_DACLRCK;
        end else begin
            case (state)
                DELAY: state_nxt = SHIFT;
                SHIFT: begin
                    if (cnt == 5'd0) state_nxt = PAD;
                    else             cnt_nxt   = cnt - 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge AUD_BCLK) begin
        // NOTE: non-blocking so every register samples the pre-edge values.
        if (rst) begin
            state      <= IDLE;
            cnt        <= 5'd0;
            chan_left  <= 1'b0;
            AUD_DACDAT <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            chan_left  <= chan_nxt;
            AUD_DACDAT <= dac_nxt;
            frame_done <= done_nxt;
        end
    end

    // Loading the live level during reset suppresses a spurious edge afterwards.
    always_ff @(posedge AUD_BCLK) begin
        lrck_q <= AUD_DACLRCK;
    end

    always_ff @(posedge AUD_BCLK) begin
        if (rst) begin
            full           <= 1'b0;
            shadow_l       <= '0;
            shadow_r       <= '0;
            underrun       <= 1'b0;
            underrun_count <= 8'd0;
        end else begin
            underrun <= starve;
            if (starve && underrun_count != 8'hFF)
                underrun_count <= underrun_count + 8'd1;

            if (left_start) begin
                full <= 1'b0;
                if (full) begin
                    shadow_l <= buf_l;
                    shadow_r <= buf_r;
                end else if (bypass) begin
                    shadow_l <= smp.sample_left;
                    shadow_r <= smp.sample_right;
                end else if (UNDERRUN_ZERO) begin
                    shadow_l <= '0;
                    shadow_r <= '0;
                end
            end else if (accept) begin
                full <= 1'b1;
            end
        end
    end

    // NOTE: buffer data needs no reset; it is only ever read while full is set.
    always_ff @(posedge AUD_BCLK) begin
        if (accept && !left_start) begin
            buf_l <= smp.sample_left;
            buf_r <= smp.sample_right;
        end
    end
endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench: one LJ/repeat-fill and one I2S/zero-fill serializer share LRCK and stimulus.
// Each slot's serial bits are packed into a word (first cycle of the slot in the MSB position).
module tb_audio_dac_serializer;
    logic       bclk = 1'b0;
    logic       rst;
    logic       lrck;
    logic       dac_lj, dac_i2s, fd_lj, fd_i2s, ur_lj, ur_i2s;
    logic [7:0] cnt_lj, cnt_i2s;

    int n_pass   = 0;
    int n_checks = 0;

    logic [31:0] cap_lj, cap_i2s, cap_fd_lj, cap_fd_i2s, cap_ur_lj, cap_ur_i2s;
    logic        rdy0, rdy1;

    audio_dac_serializer_if #(.SAMPLE_W(16)) if_lj ();
    audio_dac_serializer_if #(.SAMPLE_W(16)) if_i2s ();

    always #5 bclk = ~bclk;

    audio_dac_serializer #(.SAMPLE_W(16), .I2S_MODE(1'b0), .UNDERRUN_ZERO(1'b0)) u_lj (
        .AUD_BCLK(bclk), .rst(rst), .AUD_DACLRCK(lrck), .smp(if_lj),
        .AUD_DACDAT(dac_lj), .frame_done(fd_lj), .underrun(ur_lj), .underrun_count(cnt_lj)
    );

    audio_dac_serializer #(.SAMPLE_W(16), .I2S_MODE(1'b1), .UNDERRUN_ZERO(1'b1)) u_i2s (
        .AUD_BCLK(bclk), .rst(rst), .AUD_DACLRCK(lrck), .smp(if_i2s),
        .AUD_DACDAT(dac_i2s), .frame_done(fd_i2s), .underrun(ur_i2s), .underrun_count(cnt_i2s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive_pair(input logic [15:0] l, input logic [15:0] r, input logic v);
        if_lj.sample_left   = l;  if_lj.sample_right  = r;  if_lj.sample_valid  = v;
        if_i2s.sample_left  = l;  if_i2s.sample_right = r;  if_i2s.sample_valid = v;
    endtask

    // Called just after a negedge; leaves the pair in both buffers.
    task automatic push(input logic [15:0] l, input logic [15:0] r);
        drive_pair(l, r, 1'b1);
        @(negedge bclk);
        drive_pair(l, r, 1'b0);
    endtask

    // Sets LRCK to lvl and captures len cycles; k = 0 is the cycle the edge is sampled.
    task automatic run_slot(input logic lvl, input int len, input int drop_k);
        lrck = lvl;
        cap_lj = '0; cap_i2s = '0; cap_fd_lj = '0; cap_fd_i2s = '0; cap_ur_lj = '0; cap_ur_i2s = '0;
        for (int k = 0; k < len; k++) begin
            @(negedge bclk);
            cap_lj     = {cap_lj[30:0], dac_lj};
            cap_i2s    = {cap_i2s[30:0], dac_i2s};
            cap_fd_lj  = {cap_fd_lj[30:0], fd_lj};
            cap_fd_i2s = {cap_fd_i2s[30:0], fd_i2s};
            cap_ur_lj  = {cap_ur_lj[30:0], ur_lj};
            cap_ur_i2s = {cap_ur_i2s[30:0], ur_i2s};
            if (k == 0) rdy0 = if_lj.sample_ready;
            if (k == 1) rdy1 = if_lj.sample_ready;
            if (k == drop_k) begin
                if_lj.sample_valid  = 1'b0;
                if_i2s.sample_valid = 1'b0;
            end
        end
    endtask

    task automatic quick_frames(input int n);
        for (int f = 0; f < n; f++) begin
            lrck = 1'b1;
            repeat (2) @(negedge bclk);
            lrck = 1'b0;
            repeat (2) @(negedge bclk);
        end
    endtask

    initial begin
        rst  = 1'b1;
        lrck = 1'b0;
        drive_pair(16'h0, 16'h0, 1'b0);
        repeat (2) @(negedge bclk);
        check("rst_ready",   {31'd0, if_lj.sample_ready}, 32'd0);
        check("rst_dac",     {30'd0, dac_lj, dac_i2s}, 32'd0);
        check("rst_fd_ur",   {28'd0, fd_lj, fd_i2s, ur_lj, ur_i2s}, 32'd0);
        check("rst_count",   {16'd0, cnt_lj, cnt_i2s}, 32'd0);
        rst = 1'b0;
        @(negedge bclk);
        check("ready_after_rst", {31'd0, if_lj.sample_ready}, 32'd1);

        // Buffered pair before the first left slot.
        push(16'hA5C3, 16'h0F01);
        check("full_blocks_ready", {31'd0, if_lj.sample_ready}, 32'd0);
        run_slot(1'b1, 32, -1);
        check("lj_left_a5c3",  cap_lj,  32'h52E1_8000);
        check("i2s_left_a5c3", cap_i2s, 32'h2970_C000);
        check("left_no_fd",    cap_fd_lj | cap_fd_i2s, 32'd0);
        check("buffered_no_ur", cap_ur_lj | cap_ur_i2s, 32'd0);
        check("ready_after_load", {31'd0, rdy0}, 32'd1);
        run_slot(1'b0, 32, -1);
        check("lj_right_0f01",  cap_lj,     32'h0780_8000);
        check("i2s_right_0f01", cap_i2s,    32'h03C0_4000);
        check("lj_frame_done",  cap_fd_lj,  32'h0000_8000);
        check("i2s_frame_done", cap_fd_i2s, 32'h0000_4000);

        // Last pair 1234/5678, then three starved frames.
        push(16'h1234, 16'h5678);
        run_slot(1'b1, 32, -1);
        check("lj_left_1234",  cap_lj,  32'h091A_0000);
        check("i2s_left_1234", cap_i2s, 32'h048D_0000);
        run_slot(1'b0, 32, -1);
        check("lj_right_5678",  cap_lj,  32'h2B3C_0000);
        check("i2s_right_5678", cap_i2s, 32'h159E_0000);
        for (int f = 0; f < 3; f++) begin
            run_slot(1'b1, 32, -1);
            check("ur_repeat_left", cap_lj,     32'h091A_0000);
            check("ur_zero_left",   cap_i2s,    32'd0);
            check("ur_pulse_lj",    cap_ur_lj,  32'h8000_0000);
            check("ur_pulse_i2s",   cap_ur_i2s, 32'h8000_0000);
            run_slot(1'b0, 32, -1);
            check("ur_repeat_right", cap_lj,  32'h2B3C_0000);
            check("ur_zero_right",   cap_i2s, 32'd0);
        end
        check("ur_count_3", {16'd0, cnt_lj, cnt_i2s}, 32'h0000_0303);

        // Pair presented only in the left-start cycle with the buffer empty.
        drive_pair(16'h8001, 16'h7FFE, 1'b1);
        run_slot(1'b1, 32, 0);
        check("bypass_lj_left",  cap_lj,  32'h4000_8000);
        check("bypass_i2s_left", cap_i2s, 32'h2000_4000);
        check("bypass_no_ur",    cap_ur_lj | cap_ur_i2s, 32'd0);
        check("bypass_stays_empty", {31'd0, rdy0}, 32'd1);
        run_slot(1'b0, 32, -1);
        check("bypass_lj_right",  cap_lj,  32'h3FFF_0000);
        check("bypass_i2s_right", cap_i2s, 32'h1FFF_8000);
        check("bypass_count_3", {16'd0, cnt_lj, cnt_i2s}, 32'h0000_0303);

        // Buffer full with the next pair's valid held high across the left start.
        push(16'hC001, 16'h0003);
        drive_pair(16'h5A5A, 16'hA5A5, 1'b1);
        check("held_ready_low", {31'd0, if_lj.sample_ready}, 32'd0);
        run_slot(1'b1, 32, 1);
        check("held_ready_at_load", {31'd0, rdy0}, 32'd1);
        check("held_accepted",      {31'd0, rdy1}, 32'd0);
        check("lj_left_c001",  cap_lj,  32'h6000_8000);
        check("i2s_left_c001", cap_i2s, 32'h3000_4000);
        run_slot(1'b0, 32, -1);
        check("lj_right_0003",  cap_lj,  32'h0001_8000);
        check("i2s_right_0003", cap_i2s, 32'h0000_C000);
        run_slot(1'b1, 32, -1);
        check("lj_left_5a5a",  cap_lj,  32'h2D2D_0000);
        check("i2s_left_5a5a", cap_i2s, 32'h1696_8000);
        check("held_no_ur",    cap_ur_lj | cap_ur_i2s, 32'd0);
        run_slot(1'b0, 32, -1);
        check("lj_right_a5a5",  cap_lj,  32'h52D2_8000);
        check("i2s_right_a5a5", cap_i2s, 32'h2969_4000);

        // Left slot cut to 10 cycles: truncated, right slot starts cleanly.
        push(16'hABCD, 16'h1357);
        run_slot(1'b1, 10, -1);
        check("trunc_lj_left",  cap_lj,  32'h0000_0157);
        check("trunc_i2s_left", cap_i2s, 32'h0000_00AB);
        run_slot(1'b0, 32, -1);
        check("trunc_lj_right",  cap_lj,     32'h89AB_8000);
        check("trunc_i2s_right", cap_i2s,    32'h84D5_C000);
        check("trunc_lj_fd",     cap_fd_lj,  32'h0000_8000);
        check("trunc_i2s_fd",    cap_fd_i2s, 32'h0000_4000);

        // Saturation: 3 underruns so far, 300 more.
        quick_frames(251);
        check("count_254", {16'd0, cnt_lj, cnt_i2s}, 32'h0000_FEFE);
        quick_frames(1);
        check("count_255", {16'd0, cnt_lj, cnt_i2s}, 32'h0000_FFFF);
        quick_frames(48);
        check("count_sat", {16'd0, cnt_lj, cnt_i2s}, 32'h0000_FFFF);

        // Reset pulsed mid-SHIFT with a second pair sitting in the buffer.
        push(16'h1111, 16'h2222);
        lrck = 1'b1;
        repeat (2) @(negedge bclk);
        drive_pair(16'h9999, 16'h8888, 1'b1);
        @(negedge bclk);
        drive_pair(16'h9999, 16'h8888, 1'b0);
        check("pre_rst_full", {31'd0, if_lj.sample_ready}, 32'd0);
        repeat (2) @(negedge bclk);
        check("pre_rst_shifting", {31'd0, dac_lj}, 32'd1);
        rst = 1'b1;
        @(negedge bclk);
        check("mid_rst_dac",   {30'd0, dac_lj, dac_i2s}, 32'd0);
        check("mid_rst_ready", {31'd0, if_lj.sample_ready}, 32'd0);
        check("mid_rst_count", {16'd0, cnt_lj, cnt_i2s}, 32'd0);
        rst = 1'b0;
        @(negedge bclk);
        check("post_rst_empty", {31'd0, if_lj.sample_ready}, 32'd1);
        run_slot(1'b0, 32, -1);
        check("idle_ignores_fall", cap_lj | cap_i2s, 32'd0);
        check("idle_no_fd",        cap_fd_lj | cap_fd_i2s, 32'd0);
        run_slot(1'b1, 32, -1);
        check("post_rst_ur_lj",   cap_ur_lj,  32'h8000_0000);
        check("post_rst_ur_i2s",  cap_ur_i2s, 32'h8000_0000);
        check("post_rst_zero_pair", cap_lj | cap_i2s, 32'd0);
        check("post_rst_count", {16'd0, cnt_lj, cnt_i2s}, 32'h0000_0101);
        run_slot(1'b0, 32, -1);
        check("post_rst_resumed_lj",  cap_fd_lj,  32'h0000_8000);
        check("post_rst_resumed_i2s", cap_fd_i2s, 32'h0000_4000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
